exc_vector_loader: RTL

EXC_VECTOR_LOADER -- requirements
Module: exc_vector_loader

---
 rtl/exc_vector_loader.sv | 110 +++++++++++
 1 files changed

// File: rtl/exc_vector_loader.sv
// Exception vector loader: writes EPC, fetches a handler byte from 253..255, loads PC.
// Optional EXC_CAUSE_REG_EN keeps the last exception cause on cause_out.
module exc_vector_loader #(
  parameter int MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  mem_sel_out,
  output logic        mem_sel_valid,
  output logic [31:0] epc_out,
  output logic        epc_we,
  output logic [31:0] pc_out,
  output logic        pc_we,
  output logic        busy,
  output logic        done,
  output logic [1:0]  cause_out
);

  typedef enum logic [2:0] {
    IDLE, ADDR, WAIT, LOAD, DONE
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(MEM_WAIT - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [2:0]  sel;
  logic [31:0] epc_q;
  logic [31:0] pc_q;
  logic        exc_any;
  logic        accept;
  logic        unused_hi;

  assign exc_any   = exc_opcode | exc_overflow | exc_div0;
  assign accept    = (state == IDLE) && exc_any;
  assign unused_hi = ^mem_data_in[31:8];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= 4'd0;
      sel   <= 3'b000;
      epc_q <= 32'd0;
      pc_q  <= 32'd0;
    end else begin
      if (accept) begin
        if (exc_opcode)        sel <= 3'b100;
        else if (exc_overflow) sel <= 3'b101;
        else                   sel <= 3'b110;
        epc_q <= pc_in - 32'd4;
      end
      if (state == ADDR)      cnt <= WAIT_LD;
      else if (state == WAIT) cnt <= cnt - 4'd1;
      if (state == LOAD)
        pc_q <= {24'b0, mem_data_in[7:0]};
    end
  end

`ifdef EXC_CAUSE_REG_EN
  logic [1:0] cause_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cause_q <= 2'b00;
    end else if (accept) begin
      if (exc_opcode)        cause_q <= 2'b01;
      else if (exc_overflow) cause_q <= 2'b10;
      else                   cause_q <= 2'b11;
    end
  end

  assign cause_out = cause_q;
`else
  assign cause_out = 2'b00;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (exc_any) state_nx = ADDR;
      ADDR: state_nx = WAIT;
      WAIT: if (cnt == 4'd0) state_nx = LOAD;
      LOAD: state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handler address is visible in the LOAD cycle itself, then held.
  always_comb begin
    busy          = (state != IDLE);
    epc_we        = (state == ADDR);
    pc_we         = (state == LOAD);
    done          = (state == DONE);
    mem_sel_valid = (state == ADDR) || (state == WAIT) || (state == LOAD);
    mem_sel_out   = mem_sel_valid ? sel : 3'b000;
    epc_out       = epc_q;
    pc_out        = pc_we ? {24'b0, mem_data_in[7:0]} : pc_q;
  end

endmodule
